// File: rtl/age_scheduler.sv
// age_scheduler: reservation station with dependency wakeup and multi-port issue.
//
// Holds dispatched instructions until every producer tag in their dependency
// row has been woken, then issues up to ISSUE_W ready entries per cycle.
// Selection is oldest-first when SCHED_AGE_SELECT_EN is defined (age matrix
// present). Otherwise the lowest index wins.
//
// Optional feature macro: SCHED_AGE_SELECT_EN
//
// Ports:
//   clk            in   clock, rising edge
//   rst            in   asynchronous active-low reset
//   disp_valid     in   dispatch request
//   disp_dep_mask  in   producer tags the instruction waits on
//   disp_payload   in   opaque instruction payload
//   disp_idx       out  lowest-index free entry (combinational)
//   rs_full        out  all entries valid (combinational)
//   occupancy      out  registered count of valid entries
//   wake_vec       in   wakeup pulses, one bit per producer tag
//   iss_stall      in   suppresses all grants this cycle
//   iss_valid      out  registered per-port issue valid
//   iss_idx        out  registered per-port issued entry index
//   iss_payload    out  registered per-port issued payload
//   flush          in   synchronous squash of all entries
module age_scheduler #(
    parameter int unsigned ENTRIES   = 8,
    parameter int unsigned WAKE_W    = 16,
    parameter int unsigned ISSUE_W   = 2,
    parameter int unsigned PAYLOAD_W = 96,
    localparam int unsigned IDX_W    = $clog2(ENTRIES)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           disp_valid,
    input  logic [WAKE_W-1:0]              disp_dep_mask,
    input  logic [PAYLOAD_W-1:0]           disp_payload,
    output logic [IDX_W-1:0]               disp_idx,
    output logic                           rs_full,
    output logic [IDX_W:0]                 occupancy,
    input  logic [WAKE_W-1:0]              wake_vec,
    input  logic                           iss_stall,
    output logic [ISSUE_W-1:0]             iss_valid,
    output logic [ISSUE_W*IDX_W-1:0]       iss_idx,
    output logic [ISSUE_W*PAYLOAD_W-1:0]   iss_payload,
    input  logic                           flush
);

    logic [ENTRIES-1:0]                valid_q, valid_d;
    logic [ENTRIES-1:0][WAKE_W-1:0]    row_q, row_d;
    logic [PAYLOAD_W-1:0]              pay_q [ENTRIES];
    logic [ENTRIES-1:0]                ready;
    logic                              accept, disp_we, free_found;
    logic [ENTRIES-1:0]                cand, taken;
    logic                              oldest;
    logic [ISSUE_W-1:0]                gnt_vld;
    logic [ISSUE_W-1:0][IDX_W-1:0]     gnt_idx;
    logic [IDX_W:0]                    occ_q, occ_d, issued_cnt;
    logic [ISSUE_W-1:0]                iss_valid_q, iss_valid_d;
    logic [ISSUE_W-1:0][IDX_W-1:0]     iss_idx_q, iss_idx_d;
    logic [ISSUE_W-1:0][PAYLOAD_W-1:0] iss_pay_q, iss_pay_d;

    // ------------------------------------------------------------------
    // Dispatch side: allocation and acceptance
    // ------------------------------------------------------------------
    always_comb begin
        disp_idx   = '0;
        free_found = 1'b0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (!valid_q[i] && !free_found) begin
                free_found = 1'b1;
                disp_idx   = IDX_W'(i);
            end
        end
    end

    assign rs_full = &valid_q;
    assign accept  = disp_valid && !rs_full;
    // Flush wins over dispatch: nothing is written in a flush cycle.
    assign disp_we = accept && !flush;

    always_comb begin
        ready = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            ready[i] = valid_q[i] && (row_q[i] == '0);
        end
    end

`ifdef SCHED_AGE_SELECT_EN
    // age_q[i][j] == 1 means entry i is older than entry j (both valid).
    logic [ENTRIES-1:0][ENTRIES-1:0] age_q, age_d;

    always_comb begin
        age_d = age_q;
        if (disp_we) begin
            age_d[disp_idx] = '0;
            for (int unsigned j = 0; j < ENTRIES; j++) begin
                if (valid_q[j]) begin
                    age_d[j][disp_idx] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            age_q <= '0;
        end else begin
            age_q <= age_d;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Select: ports granted in order, each excluding entries already taken
    // by a lower port. The first qualifying index wins, so without the age
    // matrix every candidate qualifies and the lowest index is chosen.
    // ------------------------------------------------------------------
    always_comb begin
        taken   = '0;
        cand    = '0;
        oldest  = 1'b0;
        gnt_vld = '0;
        gnt_idx = '0;
        for (int unsigned p = 0; p < ISSUE_W; p++) begin
            cand = ready & ~taken;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                oldest = cand[i];
`ifdef SCHED_AGE_SELECT_EN
                for (int unsigned j = 0; j < ENTRIES; j++) begin
                    if (j != i && cand[j] && !age_q[i][j]) begin
                        oldest = 1'b0;
                    end
                end
`endif
                if (oldest && !gnt_vld[p]) begin
                    gnt_vld[p] = 1'b1;
                    gnt_idx[p] = IDX_W'(i);
                end
            end
            if (iss_stall) begin
                gnt_vld[p] = 1'b0;
            end
            if (gnt_vld[p]) begin
                taken[gnt_idx[p]] = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Entry state next-state
    // ------------------------------------------------------------------
    always_comb begin
        valid_d = valid_q;
        row_d   = row_q;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            row_d[i] = row_q[i] & ~wake_vec;
            if (taken[i]) begin
                valid_d[i] = 1'b0;
            end
            // Dispatch targets a free entry, so it never collides with a grant.
            if (disp_we && (disp_idx == IDX_W'(i))) begin
                valid_d[i] = 1'b1;
                row_d[i]   = disp_dep_mask & ~wake_vec;
            end
        end
        if (flush) begin
            valid_d = '0;
        end
    end

    always_comb begin
        issued_cnt = '0;
        for (int unsigned p = 0; p < ISSUE_W; p++) begin
            issued_cnt = issued_cnt + (IDX_W+1)'(gnt_vld[p]);
        end
        if (flush) begin
            occ_d = '0;
        end else begin
            occ_d = occ_q + (IDX_W+1)'(disp_we) - issued_cnt;
        end
    end

    always_comb begin
        iss_valid_d = '0;
        iss_idx_d   = iss_idx_q;
        iss_pay_d   = iss_pay_q;
        for (int unsigned p = 0; p < ISSUE_W; p++) begin
            iss_valid_d[p] = gnt_vld[p] && !flush;
            if (gnt_vld[p]) begin
                iss_idx_d[p] = gnt_idx[p];
                iss_pay_d[p] = pay_q[gnt_idx[p]];
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q     <= '0;
            row_q       <= '0;
            occ_q       <= '0;
            iss_valid_q <= '0;
            iss_idx_q   <= '0;
            iss_pay_q   <= '0;
        end else begin
            valid_q     <= valid_d;
            row_q       <= row_d;
            occ_q       <= occ_d;
            iss_valid_q <= iss_valid_d;
            iss_idx_q   <= iss_idx_d;
            iss_pay_q   <= iss_pay_d;
        end
    end

    // Payload RAM: contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (disp_we) begin
            pay_q[disp_idx] <= disp_payload;
        end
    end

    assign occupancy   = occ_q;
    assign iss_valid   = iss_valid_q;
    assign iss_idx     = iss_idx_q;
    assign iss_payload = iss_pay_q;

endmodule

// File: tb/tb_age_scheduler.sv
// tb_age_scheduler: directed table-driven bench for age_scheduler.
// Honours SCHED_AGE_SELECT_EN for the one vector where selection order
// differs between oldest-first and lowest-index.
module tb_age_scheduler;

    localparam int unsigned ENTRIES   = 8;
    localparam int unsigned WAKE_W    = 16;
    localparam int unsigned ISSUE_W   = 2;
    localparam int unsigned PAYLOAD_W = 96;

    logic                         clk = 1'b0;
    logic                         rst;
    logic                         disp_valid;
    logic [WAKE_W-1:0]            disp_dep_mask;
    logic [PAYLOAD_W-1:0]         disp_payload;
    logic [2:0]                   disp_idx;
    logic                         rs_full;
    logic [3:0]                   occupancy;
    logic [WAKE_W-1:0]            wake_vec;
    logic                         iss_stall;
    logic [ISSUE_W-1:0]           iss_valid;
    logic [ISSUE_W*3-1:0]         iss_idx;
    logic [ISSUE_W*PAYLOAD_W-1:0] iss_payload;
    logic                         flush;

    int checks = 0;
    int errors = 0;

    age_scheduler #(
        .ENTRIES   (ENTRIES),
        .WAKE_W    (WAKE_W),
        .ISSUE_W   (ISSUE_W),
        .PAYLOAD_W (PAYLOAD_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .disp_valid    (disp_valid),
        .disp_dep_mask (disp_dep_mask),
        .disp_payload  (disp_payload),
        .disp_idx      (disp_idx),
        .rs_full       (rs_full),
        .occupancy     (occupancy),
        .wake_vec      (wake_vec),
        .iss_stall     (iss_stall),
        .iss_valid     (iss_valid),
        .iss_idx       (iss_idx),
        .iss_payload   (iss_payload),
        .flush         (flush)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        dv;
        logic [15:0] mask;
        logic [7:0]  dst;
        logic [15:0] wake;
        logic        stall;
        logic        fl;
        logic [2:0]  e_didx;
        logic        e_full;
        logic [1:0]  e_iv;
        logic [2:0]  e_i0;
        logic [7:0]  e_p0;
        logic [2:0]  e_i1;
        logic [7:0]  e_p1;
        logic [3:0]  e_occ;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic dv, input logic [15:0] mask,
                                input logic [7:0] dst, input logic [15:0] wake,
                                input logic st, input logic fl,
                                input logic [2:0] didx, input logic full,
                                input logic [1:0] iv, input logic [2:0] i0,
                                input logic [7:0] p0, input logic [2:0] i1,
                                input logic [7:0] p1, input logic [3:0] occ);
        vec_t v;
        v.dv = dv; v.mask = mask; v.dst = dst; v.wake = wake;
        v.stall = st; v.fl = fl; v.e_didx = didx; v.e_full = full;
        v.e_iv = iv; v.e_i0 = i0; v.e_p0 = p0; v.e_i1 = i1; v.e_p1 = p1;
        v.e_occ = occ;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        disp_valid    = 1'b0;
        disp_dep_mask = '0;
        disp_payload  = '0;
        wake_vec      = '0;
        iss_stall     = 1'b0;
        flush         = 1'b0;
    endtask

    initial begin
        vec_t v;
        // dv  mask     dst    wake     st fl didx full iv    i0 p0     i1 p1     occ
        // single ready instruction: 2-edge latency
        vq.push_back(mk(1, 16'h0000, 8'd10, 16'h0000, 0, 0, 0, 0, 2'b00, 0, 0,     0, 0,     1));
        vq.push_back(mk(0, 16'h0000, 8'd0,  16'h0000, 0, 0, 1, 0, 2'b01, 0, 8'd10, 0, 0,     0));
        vq.push_back(mk(0, 16'h0000, 8'd0,  16'h0000, 0, 0, 0, 0, 2'b00, 0, 0,     0, 0,     0));
        // two dependencies woken one at a time
        vq.push_back(mk(1, 16'h0003, 8'd20, 16'h0000, 0, 0, 0, 0, 2'b00, 0, 0,     0, 0,     1));
        vq.push_back(mk(0, 16'h0000, 8'd0,  16'h0001, 0, 0, 1, 0, 2'b00, 0, 0,     0, 0,     1));
        vq.push_back(mk(0, 16'h0000, 8'd0,  16'h0000, 0, 0, 1, 0, 2'b00, 0, 0,     0, 0,     1));
        vq.push_back(mk(0, 16'h0000, 8'd0,  16'h0002, 0, 0, 1, 0, 2'b00, 0, 0,     0, 0,     1));
        vq.push_back(mk(0, 16'h0000, 8'd0,  16'h0000, 0, 0, 1, 0, 2'b01, 0, 8'd20, 0, 0,     0));
        // wakeup bypass on the dispatch cycle
        vq.push_back(mk(1, 16'h0004, 8'd30, 16'h0004, 0, 0, 0, 0, 2'b00, 0, 0,     0, 0,     1));
        vq.push_back(mk(0, 16'h0000, 8'd0,  16'h0000, 0, 0, 1, 0, 2'b01, 0, 8'd30, 0, 0,     0));
        // dispatch and issue in the same cycle
        vq.push_back(mk(1, 16'h0000, 8'd40, 16'h0000, 0, 0, 0, 0, 2'b00, 0, 0,     0, 0,     1));
        vq.push_back(mk(1, 16'h0000, 8'd41, 16'h0000, 0, 0, 1, 0, 2'b01, 0, 8'd40, 0, 0,     1));
        vq.push_back(mk(0, 16'h0000, 8'd0,  16'h0000, 0, 0, 0, 0, 2'b01, 1, 8'd41, 0, 0,     0));
        // stall with three ready entries, then 2 + 1 issue
        vq.push_back(mk(1, 16'h0000, 8'd50, 16'h0000, 1, 0, 0, 0, 2'b00, 0, 0,     0, 0,     1));
        vq.push_back(mk(1, 16'h0000, 8'd51, 16'h0000, 1, 0, 1, 0, 2'b00, 0, 0,     0, 0,     2));
        vq.push_back(mk(1, 16'h0000, 8'd52, 16'h0000, 1, 0, 2, 0, 2'b00, 0, 0,     0, 0,     3));
        for (int k = 0; k < 4; k++)
            vq.push_back(mk(0, 16'h0000, 8'd0, 16'h0000, 1, 0, 3, 0, 2'b00, 0, 0, 0, 0, 3));
        vq.push_back(mk(0, 16'h0000, 8'd0,  16'h0000, 0, 0, 3, 0, 2'b11, 0, 8'd50, 1, 8'd51, 1));
        vq.push_back(mk(0, 16'h0000, 8'd0,  16'h0000, 0, 0, 0, 0, 2'b01, 2, 8'd52, 0, 0,     0));
        vq.push_back(mk(0, 16'h0000, 8'd0,  16'h0000, 0, 0, 0, 0, 2'b00, 0, 0,     0, 0,     0));
        // fill all entries with a pending dependency
        for (int k = 0; k < 8; k++)
            vq.push_back(mk(1, 16'h0001, 8'(60 + k), 16'h0000, 0, 0, 3'(k), 0, 2'b00, 0, 0, 0, 0, 4'(k + 1)));
        // dispatch while full is dropped
        vq.push_back(mk(1, 16'h0000, 8'd99, 16'h0000, 0, 0, 0, 1, 2'b00, 0, 0,     0, 0,     8));
        vq.push_back(mk(0, 16'h0000, 8'd0,  16'h0000, 0, 0, 0, 1, 2'b00, 0, 0,     0, 0,     8));
        vq.push_back(mk(0, 16'h0000, 8'd0,  16'h0001, 0, 0, 0, 1, 2'b00, 0, 0,     0, 0,     8));
        vq.push_back(mk(0, 16'h0000, 8'd0,  16'h0000, 0, 0, 0, 1, 2'b11, 0, 8'd60, 1, 8'd61, 6));
        vq.push_back(mk(1, 16'h0000, 8'd70, 16'h0000, 0, 0, 0, 0, 2'b11, 2, 8'd62, 3, 8'd63, 5));
        // flush with coincident dispatch, wakeup and pending grants
        vq.push_back(mk(1, 16'h0000, 8'd71, 16'hFFFF, 0, 1, 1, 0, 2'b00, 0, 0,     0, 0,     0));
        vq.push_back(mk(0, 16'h0000, 8'd0,  16'h0000, 0, 0, 0, 0, 2'b00, 0, 0,     0, 0,     0));
        // age sequence: C (entry 2) older than D (entry 0)
        vq.push_back(mk(1, 16'h0002, 8'hA0, 16'h0000, 0, 0, 0, 0, 2'b00, 0, 0,     0, 0,     1));
        vq.push_back(mk(1, 16'h0000, 8'hB0, 16'h0000, 0, 0, 1, 0, 2'b00, 0, 0,     0, 0,     2));
        vq.push_back(mk(1, 16'h0001, 8'hC0, 16'h0000, 0, 0, 2, 0, 2'b01, 1, 8'hB0, 0, 0,     2));
        vq.push_back(mk(0, 16'h0000, 8'd0,  16'h0002, 0, 0, 1, 0, 2'b00, 0, 0,     0, 0,     2));
        vq.push_back(mk(0, 16'h0000, 8'd0,  16'h0000, 0, 0, 1, 0, 2'b01, 0, 8'hA0, 0, 0,     1));
        vq.push_back(mk(1, 16'h0000, 8'hD0, 16'h0001, 0, 0, 0, 0, 2'b00, 0, 0,     0, 0,     2));
`ifdef SCHED_AGE_SELECT_EN
        vq.push_back(mk(0, 16'h0000, 8'd0,  16'h0000, 0, 0, 1, 0, 2'b11, 2, 8'hC0, 0, 8'hD0, 0));
`else
        vq.push_back(mk(0, 16'h0000, 8'd0,  16'h0000, 0, 0, 1, 0, 2'b11, 0, 8'hD0, 2, 8'hC0, 0));
`endif
        vq.push_back(mk(0, 16'h0000, 8'd0,  16'h0000, 0, 0, 0, 0, 2'b00, 0, 0,     0, 0,     0));

        // Reset state
        rst = 1'b0;
        idle_inputs();
        #3;
        check("rst iss_valid", 32'(iss_valid), 0);
        check("rst occupancy", 32'(occupancy), 0);
        check("rst rs_full",   32'(rs_full),   0);
        check("rst disp_idx",  32'(disp_idx),  0);
        check("rst iss_idx",   32'(iss_idx),   0);
        check("rst payload",   32'(iss_payload[31:0]), 0);
        #5;
        rst = 1'b1;
        @(posedge clk); #1;

        // Table-driven vectors
        for (int n = 0; n < vq.size(); n++) begin
            v = vq[n];
            disp_valid    = v.dv;
            disp_dep_mask = v.mask;
            disp_payload  = {88'd0, v.dst};
            wake_vec      = v.wake;
            iss_stall     = v.stall;
            flush         = v.fl;
            #1;
            check($sformatf("v%0d disp_idx", n), 32'(disp_idx), 32'(v.e_didx));
            check($sformatf("v%0d rs_full", n),  32'(rs_full),  32'(v.e_full));
            @(posedge clk); #1;
            check($sformatf("v%0d iss_valid", n), 32'(iss_valid), 32'(v.e_iv));
            check($sformatf("v%0d occupancy", n), 32'(occupancy), 32'(v.e_occ));
            if (v.e_iv[0]) begin
                check($sformatf("v%0d idx0", n), 32'(iss_idx[2:0]),     32'(v.e_i0));
                check($sformatf("v%0d pay0", n), 32'(iss_payload[7:0]), 32'(v.e_p0));
            end
            if (v.e_iv[1]) begin
                check($sformatf("v%0d idx1", n), 32'(iss_idx[5:3]),                          32'(v.e_i1));
                check($sformatf("v%0d pay1", n), 32'(iss_payload[PAYLOAD_W+7:PAYLOAD_W]), 32'(v.e_p1));
            end
        end

        // Asynchronous reset mid-run discards entries and clears outputs at once
        idle_inputs();
        disp_valid   = 1'b1;
        disp_payload = {88'd0, 8'd80};
        @(posedge clk); #1;
        disp_payload = {88'd0, 8'd81};
        @(posedge clk); #1;
        idle_inputs();
        check("pre-rst iss_valid", 32'(iss_valid), 32'h1);
        check("pre-rst payload",   32'(iss_payload[7:0]), 32'd80);
        rst = 1'b0;
        #1;
        check("mid-rst iss_valid", 32'(iss_valid), 0);
        check("mid-rst occupancy", 32'(occupancy), 0);
        check("mid-rst rs_full",   32'(rs_full),   0);
        check("mid-rst disp_idx",  32'(disp_idx),  0);
        check("mid-rst iss_idx",   32'(iss_idx),   0);
        check("mid-rst payload",   32'(iss_payload[7:0]), 0);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("post-rst iss_valid", 32'(iss_valid), 0);
        check("post-rst occupancy", 32'(occupancy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
